// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
//   Shared definitions for the unified instruction/data memory port arbiter:
//   state encoding, the default memory latency (also used by the memory model
//   and the testbench) and the latency counter width.
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

  // Default memory read/write latency in cycles (legal range 1..15).
  localparam int DEFAULT_MEM_LAT = 2;

  // Latency counter width: 4 bits covers MEM_LAT up to 15.
  localparam int CNT_W = 4;

  // Arbiter state encoding.
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_BUSY_IF  = 2'd1;
  localparam logic [1:0] ST_BUSY_MEM = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE     = ST_IDLE,
    S_BUSY_IF  = ST_BUSY_IF,
    S_BUSY_MEM = ST_BUSY_MEM
  } arb_state_t;

endpackage : mem_port_arbiter_pkg

// File: rtl/mem_port_arbiter_timer.sv
// -----------------------------------------------------------------------------
// mem_lat_timer
//   Loadable down-counter that times one memory access. A start pulse loads
//   lat-1 and arms the timer; `last` is high during the final cycle of the
//   access, after which the timer disarms itself.
//
// Ports:
//   clk    in   system clock
//   rstn   in   asynchronous active-low reset
//   start  in   load the counter (one cycle, only while disarmed)
//   lat    in   access length in cycles, 1..15
//   last   out  high in the last cycle of the timed access
// -----------------------------------------------------------------------------
module mem_lat_timer
  import mem_port_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [CNT_W-1:0] lat,
  output logic             last
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic             active_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (start) begin
      cnt_q    <= lat - CNT_ONE;
      active_q <= 1'b1;
    end else if (active_q) begin
      if (cnt_q == '0) begin
        active_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - CNT_ONE;
      end
    end
  end

  assign last = active_q && (cnt_q == '0);

endmodule : mem_lat_timer

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-port unified memory between the IF-stage fetch and the
//   MEM-stage load/store. MEM has priority over IF (older instruction). Each
//   access occupies the bus for exactly MEM_LAT cycles, is never preempted and
//   finishes with a registered read-data capture and a one-cycle done pulse.
//   Stall outputs hold the pipeline while a request is outstanding.
//
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   if_req/if_addr            fetch request (level, held until if_done)
//   if_rdata/if_done          fetched instruction (registered), done pulse
//   mem_req/mem_we/mem_addr/mem_wdata   load/store request
//   mem_rdata/mem_done        load data (registered), done pulse
//   bus_en/bus_we/bus_addr/bus_wdata    memory-side command, stable while busy
//   bus_rdata                 memory read data, valid in the last busy cycle
//   stall_if/stall_mem        requester waiting for completion
//   conflict_cnt              saturating count of contested IDLE cycles
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_LAT = DEFAULT_MEM_LAT,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_done,
  output logic              bus_en,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              stall_if,
  output logic              stall_mem,
  output logic [15:0]       conflict_cnt
);

  localparam logic [CNT_W-1:0] LAT = CNT_W'(MEM_LAT);

  arb_state_t        state_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] mem_rdata_q;
  logic              if_done_q;
  logic              mem_done_q;
  logic              bus_en_q;
  logic              bus_we_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [DATA_W-1:0] bus_wdata_q;
  logic [15:0]       conflict_q;

  logic elig_if;
  logic elig_mem;
  logic idle;
  logic grant_mem;
  logic grant_if;
  logic access_last;

  // A requester whose done pulse is showing is retiring this cycle; excluding
  // it stops the still-high level request from being granted a second time.
  assign elig_if   = if_req  && !if_done_q;
  assign elig_mem  = mem_req && !mem_done_q;
  assign idle      = (state_q == S_IDLE);
  assign grant_mem = idle && elig_mem;
  assign grant_if  = idle && !elig_mem && elig_if;

  mem_lat_timer u_timer (
    .clk   (clk),
    .rstn  (rstn),
    .start (grant_mem || grant_if),
    .lat   (LAT),
    .last  (access_last)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      bus_en_q    <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      conflict_q  <= '0;
    end else begin
      // Done outputs are pulses: cleared every cycle unless set below.
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          if (elig_if && elig_mem && (conflict_q != 16'hFFFF)) begin
            conflict_q <= conflict_q + 16'd1;
          end
          if (grant_mem) begin
            state_q     <= S_BUSY_MEM;
            bus_en_q    <= 1'b1;
            bus_we_q    <= mem_we;
            bus_addr_q  <= mem_addr;
            bus_wdata_q <= mem_wdata;
          end else if (grant_if) begin
            state_q     <= S_BUSY_IF;
            bus_en_q    <= 1'b1;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= if_addr;
            bus_wdata_q <= '0;
          end
        end

        S_BUSY_IF: begin
          if (access_last) begin
            state_q    <= S_IDLE;
            if_done_q  <= 1'b1;
            if_rdata_q <= bus_rdata;
            bus_en_q   <= 1'b0;
            bus_we_q   <= 1'b0;
          end
        end

        S_BUSY_MEM: begin
          if (access_last) begin
            state_q    <= S_IDLE;
            mem_done_q <= 1'b1;
            // Stores leave the last load result visible.
            if (!bus_we_q) begin
              mem_rdata_q <= bus_rdata;
            end
            bus_en_q <= 1'b0;
            bus_we_q <= 1'b0;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign if_rdata     = if_rdata_q;
  assign mem_rdata    = mem_rdata_q;
  assign if_done      = if_done_q;
  assign mem_done     = mem_done_q;
  assign bus_en       = bus_en_q;
  assign bus_we       = bus_we_q;
  assign bus_addr     = bus_addr_q;
  assign bus_wdata    = bus_wdata_q;
  assign conflict_cnt = conflict_q;
  assign stall_if     = if_req  && !if_done_q;
  assign stall_mem    = mem_req && !mem_done_q;

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Self-checking bench for mem_port_arbiter. Each completion expected from a
//   request is pushed to a scoreboard queue when the request is driven and
//   popped when the matching done pulse is observed. Inputs are driven on the
//   falling edge; outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int LAT = DEFAULT_MEM_LAT;

  typedef struct {
    logic        is_mem;
    logic [31:0] rdata;
  } sb_entry_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        bus_en;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        stall_if;
  logic        stall_mem;
  logic [15:0] conflict_cnt;

  int          checks = 0;
  int          errors = 0;
  sb_entry_t   sb[$];
  logic [31:0] exp_mem_rdata = '0;
  logic [15:0] exp_conflict  = '0;

  always #5 clk = ~clk;

  // Memory model: one known instruction word, otherwise an address pattern.
  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h0000_1000) return 32'h0050_0093;
    return {a[15:0], ~a[15:0]};
  endfunction

  assign bus_rdata = mem_model(bus_addr);

  mem_port_arbiter #(
    .MEM_LAT (LAT),
    .ADDR_W  (32),
    .DATA_W  (32)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_rdata     (if_rdata),
    .if_done      (if_done),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_done     (mem_done),
    .bus_en       (bus_en),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_rdata    (bus_rdata),
    .stall_if     (stall_if),
    .stall_mem    (stall_mem),
    .conflict_cnt (conflict_cnt)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    sb_entry_t e;
    rstn = 1'b0; if_req = 1'b1; if_addr = 32'h0000_1010;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_3000; mem_wdata = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({bus_en, bus_we, if_done, mem_done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 0000", {bus_en, bus_we, if_done, mem_done});
    end
    checks++;
    if ({bus_addr, bus_wdata, if_rdata, mem_rdata, conflict_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_data: addr %h wdata %h if_rd %h mem_rd %h cc %h want all 0",
               bus_addr, bus_wdata, if_rdata, mem_rdata, conflict_cnt);
    end
    // Release: both requesters eligible in this IDLE cycle, MEM wins.
    @(negedge clk);
    rstn = 1'b1;
    sb.push_back('{is_mem: 1'b1, rdata: mem_model(32'h0000_3000)});
    exp_conflict++;
    #1;
    checks++;
    if (bus_en !== 1'b0) begin
      errors++; $display("FAIL reset_release_T0: bus_en %b want 0", bus_en);
    end
    for (int i = 0; i < LAT; i++) begin
      @(negedge clk);
      if_req = 1'b0;
      #1;
      checks++;
      if ({bus_en, bus_we, bus_addr} !== {1'b1, 1'b0, 32'h0000_3000}) begin
        errors++;
        $display("FAIL reset_grant_mem: en %b we %b addr %h want 1 0 00003000", bus_en, bus_we, bus_addr);
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (!mem_done || sb.size() == 0) begin
      errors++; $display("FAIL reset_mem_done: done %b queued %0d want 1", mem_done, sb.size());
    end else begin
      e = sb.pop_front();
      exp_mem_rdata = e.rdata;
      checks++;
      if (e.is_mem !== 1'b1 || mem_rdata !== e.rdata) begin
        errors++; $display("FAIL reset_mem_rdata: got %h want %h", mem_rdata, e.rdata);
      end
    end
    mem_req = 1'b0;
    checks++;
    if (conflict_cnt !== exp_conflict) begin
      errors++; $display("FAIL reset_conflict: got %0d want %0d", conflict_cnt, exp_conflict);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({bus_en, mem_done, if_done} !== 3'b000) begin
      errors++; $display("FAIL reset_idle_after: en/mdone/idone %b want 000", {bus_en, mem_done, if_done});
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_fetch_only();
    sb_entry_t e;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0000_1000;
    sb.push_back('{is_mem: 1'b0, rdata: 32'h0050_0093});
    #1;
    checks++;
    if ({stall_if, bus_en} !== 2'b10) begin
      errors++; $display("FAIL fetch_T0: stall_if/bus_en %b want 10", {stall_if, bus_en});
    end
    for (int i = 0; i < LAT; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({bus_en, bus_we, bus_addr, stall_if, if_done} !== {2'b10, 32'h0000_1000, 2'b10}) begin
        errors++;
        $display("FAIL fetch_busy: en %b we %b addr %h stall %b done %b want 1 0 00001000 1 0",
                 bus_en, bus_we, bus_addr, stall_if, if_done);
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (!if_done || stall_if || sb.size() == 0) begin
      errors++; $display("FAIL fetch_done: done %b stall %b want 1 0", if_done, stall_if);
    end else begin
      e = sb.pop_front();
      checks++;
      if (e.is_mem !== 1'b0 || if_rdata !== e.rdata) begin
        errors++; $display("FAIL fetch_rdata: got %h want %h", if_rdata, e.rdata);
      end
    end
    if_req = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({bus_en, if_done} !== 2'b00) begin
      errors++; $display("FAIL fetch_after: en/done %b want 00", {bus_en, if_done});
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_conflict();
    sb_entry_t e;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0000_1004;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_2000;
    sb.push_back('{is_mem: 1'b1, rdata: mem_model(32'h0000_2000)});
    sb.push_back('{is_mem: 1'b0, rdata: mem_model(32'h0000_1004)});
    exp_conflict++;
    for (int i = 0; i < LAT; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({bus_en, bus_addr, stall_if, stall_mem} !== {1'b1, 32'h0000_2000, 2'b11}) begin
        errors++;
        $display("FAIL conflict_busy_mem: en %b addr %h stall_if %b stall_mem %b",
                 bus_en, bus_addr, stall_if, stall_mem);
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (!mem_done || stall_mem || !stall_if || sb.size() == 0) begin
      errors++;
      $display("FAIL conflict_mem_done: done %b stall_mem %b stall_if %b", mem_done, stall_mem, stall_if);
    end else begin
      e = sb.pop_front();
      exp_mem_rdata = e.rdata;
      checks++;
      if (e.is_mem !== 1'b1 || mem_rdata !== e.rdata) begin
        errors++; $display("FAIL conflict_mem_rdata: got %h want %h", mem_rdata, e.rdata);
      end
    end
    mem_req = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({bus_en, bus_we, bus_addr, stall_if} !== {2'b10, 32'h0000_1004, 1'b1}) begin
        errors++;
        $display("FAIL conflict_busy_if: en %b we %b addr %h stall_if %b", bus_en, bus_we, bus_addr, stall_if);
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (!if_done || sb.size() == 0) begin
      errors++; $display("FAIL conflict_if_done: done %b want 1", if_done);
    end else begin
      e = sb.pop_front();
      checks++;
      if (e.is_mem !== 1'b0 || if_rdata !== e.rdata) begin
        errors++; $display("FAIL conflict_if_rdata: got %h want %h", if_rdata, e.rdata);
      end
    end
    if_req = 1'b0;
    checks++;
    if (conflict_cnt !== exp_conflict) begin
      errors++; $display("FAIL conflict_cnt: got %0d want %0d", conflict_cnt, exp_conflict);
    end
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_store();
    sb_entry_t e;
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h0000_2004; mem_wdata = 32'hDEAD_BEEF;
    sb.push_back('{is_mem: 1'b1, rdata: exp_mem_rdata});
    for (int i = 0; i < LAT; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({bus_en, bus_we, bus_addr, bus_wdata} !== {2'b11, 32'h0000_2004, 32'hDEAD_BEEF}) begin
        errors++;
        $display("FAIL store_busy: en %b we %b addr %h wdata %h", bus_en, bus_we, bus_addr, bus_wdata);
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (!mem_done || bus_en || bus_we || sb.size() == 0) begin
      errors++; $display("FAIL store_done: done %b en %b we %b want 1 0 0", mem_done, bus_en, bus_we);
    end else begin
      e = sb.pop_front();
      checks++;
      if (mem_rdata !== e.rdata) begin
        errors++; $display("FAIL store_rdata_hold: got %h want %h", mem_rdata, e.rdata);
      end
    end
    mem_req = 1'b0; mem_we = 1'b0;
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid_access();
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_2008;
    @(negedge clk);
    #1;
    checks++;
    if (bus_en !== 1'b1) begin
      errors++; $display("FAIL rstmid_T1: bus_en %b want 1", bus_en);
    end
    rstn = 1'b0;
    mem_req = 1'b0;
    #1;
    exp_mem_rdata = '0;
    exp_conflict  = '0;
    checks++;
    if ({bus_en, bus_we, bus_addr, mem_rdata, if_rdata, conflict_cnt} !== '0) begin
      errors++;
      $display("FAIL rstmid_clear: en %b we %b addr %h mem_rd %h if_rd %h cc %0d want all 0",
               bus_en, bus_we, bus_addr, mem_rdata, if_rdata, conflict_cnt);
    end
    for (int i = 0; i < LAT + 1; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (mem_done !== 1'b0) begin
        errors++; $display("FAIL rstmid_no_done: mem_done %b want 0", mem_done);
      end
    end
    rstn = 1'b1;
    test_fetch_only();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_flush();
    sb_entry_t e;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0000_1008;
    sb.push_back('{is_mem: 1'b0, rdata: mem_model(32'h0000_1008)});
    for (int i = 0; i < LAT; i++) begin
      @(negedge clk);
      if_req = 1'b0;
      #1;
      checks++;
      if ({bus_en, bus_addr} !== {1'b1, 32'h0000_1008}) begin
        errors++; $display("FAIL flush_busy: en %b addr %h want 1 00001008", bus_en, bus_addr);
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (!if_done || sb.size() == 0) begin
      errors++; $display("FAIL flush_done: if_done %b want 1", if_done);
    end else begin
      e = sb.pop_front();
      checks++;
      if (if_rdata !== e.rdata) begin
        errors++; $display("FAIL flush_rdata: got %h want %h", if_rdata, e.rdata);
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if ({bus_en, if_done, mem_done} !== 3'b000) begin
      errors++; $display("FAIL flush_no_regrant: en/idone/mdone %b want 000", {bus_en, if_done, mem_done});
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_no_preempt();
    sb_entry_t e;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0000_100C;
    sb.push_back('{is_mem: 1'b0, rdata: mem_model(32'h0000_100C)});
    for (int i = 0; i < LAT; i++) begin
      @(negedge clk);
      if (i == 0) begin
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_2010;
        sb.push_back('{is_mem: 1'b1, rdata: mem_model(32'h0000_2010)});
      end
      #1;
      checks++;
      if ({bus_en, bus_addr, stall_mem} !== {1'b1, 32'h0000_100C, 1'b1}) begin
        errors++; $display("FAIL nopre_busy_if: en %b addr %h stall_mem %b", bus_en, bus_addr, stall_mem);
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (!if_done || sb.size() == 0) begin
      errors++; $display("FAIL nopre_if_done: if_done %b want 1", if_done);
    end else begin
      e = sb.pop_front();
      checks++;
      if (e.is_mem !== 1'b0 || if_rdata !== e.rdata) begin
        errors++; $display("FAIL nopre_if_rdata: got %h want %h", if_rdata, e.rdata);
      end
    end
    if_req = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({bus_en, bus_addr} !== {1'b1, 32'h0000_2010}) begin
        errors++; $display("FAIL nopre_busy_mem: en %b addr %h want 1 00002010", bus_en, bus_addr);
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (!mem_done || sb.size() == 0) begin
      errors++; $display("FAIL nopre_mem_done: mem_done %b want 1", mem_done);
    end else begin
      e = sb.pop_front();
      exp_mem_rdata = e.rdata;
      checks++;
      if (e.is_mem !== 1'b1 || mem_rdata !== e.rdata) begin
        errors++; $display("FAIL nopre_mem_rdata: got %h want %h", mem_rdata, e.rdata);
      end
    end
    mem_req = 1'b0;
    checks++;
    if (conflict_cnt !== exp_conflict) begin
      errors++; $display("FAIL nopre_conflict: got %0d want %0d", conflict_cnt, exp_conflict);
    end
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_fetch_only();
    test_conflict();
    test_store();
    test_reset_mid_access();
    test_flush();
    test_no_preempt();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d entries left want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mem_port_arbiter
